// File: rtl/ex_issue_ctrl_pkg.sv
// Shared types for the EX-stage issue controller.
package ex_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_HOLD = 2'd2
  } ex_ctrl_state_e;

endpackage

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: sequences one instruction through ALU / mult / div,
// holds results under WB back-pressure, handles flush and flags over-long multicycle ops.
module ex_issue_ctrl #(
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic             mult_sel_i,
  input  logic             div_sel_i,
  input  logic             ex_valid_i,
  input  logic             wb_ready_i,
  input  logic             flush_i,
  output logic             alu_instr_first_cycle_o,
  output logic             mult_en_o,
  output logic             div_en_o,
  output logic             multdiv_ready_id_o,
  output logic             ex_ready_o,
  output logic             ex_retire_o,
  output logic [CNT_W-1:0] ex_cycles_o,
  output logic             err_timeout_o
);
  import ex_issue_ctrl_pkg::*;

  // The flag sets on the edge where the counter steps onto TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  ex_ctrl_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             active, first_cycle, done;

  always_comb begin
    state_d     = state_q;
    active      = id_valid_i & ~flush_i;
    first_cycle = (state_q == EX_IDLE) & id_valid_i;
    done        = active & ex_valid_i & wb_ready_i;

    unique case (state_q)
      EX_IDLE: begin
        if (id_valid_i) begin
          if (done)            state_d = EX_IDLE;
          else if (ex_valid_i) state_d = EX_HOLD;
          else                 state_d = EX_BUSY;
        end
      end
      EX_BUSY: begin
        if (!id_valid_i)                   state_d = EX_IDLE;
        else if (ex_valid_i && wb_ready_i) state_d = EX_IDLE;
        else if (ex_valid_i)               state_d = EX_HOLD;
      end
      EX_HOLD: begin
        if (!id_valid_i || wb_ready_i) state_d = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase

    // Flush overrides every transition, including a fresh issue in IDLE.
    if (flush_i) state_d = EX_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EX_IDLE;
    else       state_q <= state_d;
  end

  // Counter keeps the last instruction's count until the next issue reloads it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (first_cycle) begin
      cnt_q <= CNT_ONE;
      err_q <= 1'b0;
    end else if (state_q != EX_IDLE) begin
      cnt_q <= sat_inc(cnt_q);
      if (state_q == EX_BUSY && cnt_q >= TIMEOUT_M1) err_q <= 1'b1;
    end
  end

  assign alu_instr_first_cycle_o = first_cycle;
  assign mult_en_o               = active & mult_sel_i;
  assign div_en_o                = active & div_sel_i;
  assign multdiv_ready_id_o      = wb_ready_i;
  assign ex_retire_o             = done;
  assign ex_ready_o              = done | ((state_q == EX_IDLE) & ~id_valid_i) | flush_i;
  assign ex_cycles_o             = cnt_q;
  assign err_timeout_o           = err_q;

`ifndef SYNTHESIS
  a_id_valid_held : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q != EX_IDLE && !flush_i) |-> id_valid_i);
  a_hold_ex_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == EX_HOLD && !flush_i) |-> ex_valid_i);
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Randomized bench for ex_issue_ctrl against an instruction-level reference model.
module tb_ex_issue_ctrl;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 40;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, mult_sel, div_sel, ex_valid, wb_ready, flush;
  logic             first_cycle, mult_en, div_en, md_ready, ex_ready, ex_retire, err_timeout;
  logic [CNT_W-1:0] ex_cycles;

  int checks = 0;
  int errors = 0;

  // Model: is an instruction occupying EX, is its result waiting on WB, cycles spent, error flag.
  bit m_inflight = 0;
  bit m_held     = 0;
  bit m_err      = 0;
  int m_cycles   = 0;

  ex_issue_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .id_valid_i             (id_valid),
    .mult_sel_i             (mult_sel),
    .div_sel_i              (div_sel),
    .ex_valid_i             (ex_valid),
    .wb_ready_i             (wb_ready),
    .flush_i                (flush),
    .alu_instr_first_cycle_o(first_cycle),
    .mult_en_o              (mult_en),
    .div_en_o               (div_en),
    .multdiv_ready_id_o     (md_ready),
    .ex_ready_o             (ex_ready),
    .ex_retire_o            (ex_retire),
    .ex_cycles_o            (ex_cycles),
    .err_timeout_o          (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; drives one cycle, checks at the falling edge,
  // then advances the model across the next rising edge.
  task automatic step(input bit iv, input bit ms, input bit ds, input bit ev, input bit wr,
                      input bit fl);
    bit exp_first, act, exp_done, exp_ready;
    id_valid = iv; mult_sel = ms; div_sel = ds; ex_valid = ev; wb_ready = wr; flush = fl;
    #4;
    exp_first = !m_inflight && iv;
    act       = iv && !fl;
    exp_done  = act && ev && wr;
    exp_ready = exp_done || (!m_inflight && !iv) || fl;
    check_val("first_cycle", 32'(first_cycle), 32'(exp_first));
    check_val("mult_en",     32'(mult_en),     32'(act && ms));
    check_val("div_en",      32'(div_en),      32'(act && ds));
    check_val("md_ready",    32'(md_ready),    32'(wr));
    check_val("ex_retire",   32'(ex_retire),   32'(exp_done));
    check_val("ex_ready",    32'(ex_ready),    32'(exp_ready));
    check_val("ex_cycles",   32'(ex_cycles),   32'((m_cycles > CNT_MAX) ? CNT_MAX : m_cycles));
    check_val("err_timeout", 32'(err_timeout), 32'(m_err));
    @(posedge clk);
    if (exp_first) begin
      m_cycles = 1;
      m_err    = 0;
    end else if (m_inflight) begin
      m_cycles++;
      if (!m_held && m_cycles >= TIMEOUT) m_err = 1;
    end
    m_inflight = iv && !fl && !exp_done;
    m_held     = m_inflight && ev;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 0; mult_sel = 0; div_sel = 0; ex_valid = 0; wb_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ready",  32'(ex_ready),    32'd1);
    check_val("rst_first",  32'(first_cycle), 32'd0);
    check_val("rst_retire", 32'(ex_retire),   32'd0);
    check_val("rst_cycles", 32'(ex_cycles),   32'd0);
    check_val("rst_err",    32'(err_timeout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle ALU op
    step(1, 0, 0, 1, 1, 0);
    check_val("alu_cycles", 32'(ex_cycles), 32'd1);
    step(0, 0, 0, 0, 1, 0);

    // Multiply, result on cycle 3
    for (int c = 1; c <= 3; c++) step(1, 1, 0, c == 3, 1, 0);
    check_val("mul_cycles", 32'(ex_cycles), 32'd3);

    // Divide with result on cycle 37 and WB stalled through cycle 39
    for (int c = 1; c <= 40; c++) step(1, 0, 1, c >= 37, !(c >= 37 && c <= 39), 0);
    check_val("div_cycles", 32'(ex_cycles), 32'd40);
    check_val("div_err",    32'(err_timeout), 32'd0);

    // Flush on cycle 5 of a divide
    for (int c = 1; c <= 5; c++) step(1, 0, 1, 0, 1, c == 5);
    step(0, 0, 0, 0, 1, 0);

    // Divide that never completes: timeout, saturation, then cleared by next issue
    for (int c = 1; c <= 70; c++) step(1, 0, 1, 0, 1, 0);
    check_val("to_err",     32'(err_timeout), 32'd1);
    check_val("to_cycles",  32'(ex_cycles),   32'(CNT_MAX));
    step(1, 0, 1, 0, 1, 1);
    check_val("to_err_kept", 32'(err_timeout), 32'd1);
    step(1, 0, 0, 1, 1, 0);
    check_val("to_err_clr", 32'(err_timeout), 32'd0);

    // Asynchronous reset in the middle of a multiply
    for (int c = 1; c <= 3; c++) step(1, 1, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_cycles", 32'(ex_cycles),   32'd0);
    check_val("arst_first",  32'(first_cycle), 32'd1);
    id_valid = 0;
    #1;
    check_val("arst_ready",  32'(ex_ready),    32'd1);
    m_inflight = 0; m_held = 0; m_err = 0; m_cycles = 0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      int kind, lat, stall, fcyc;
      bit ms, ds, ev, wr, fl;
      kind  = $urandom_range(0, 2);
      ms    = (kind == 1);
      ds    = (kind == 2);
      lat   = (kind == 0) ? 1 : (kind == 1) ? $urandom_range(1, 5) : $urandom_range(1, 45);
      stall = $urandom_range(0, 3);
      fcyc  = ($urandom_range(0, 5) == 0) ? $urandom_range(2, lat + stall + 1) : 0;
      for (int c = 1; c <= 100; c++) begin
        ev = (c >= lat);
        wr = (c >= lat + stall);
        fl = (c == fcyc);
        step(1, ms, ds, ev, wr, fl);
        if (fl || (ev && wr)) break;
      end
      for (int g = $urandom_range(0, 2); g > 0; g--)
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
